sys_array_mm: RTL
=================

Name: sys_array_mm

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply engine: computes C = A x B, with A of size N x K and B of size K x N.
- Generation-two successor of the single MAC block. Adds valid-tagged data, internal input skew, signed mode, configurable accumulator width, a control FSM and a handshaked result read-out.
- Sits between the operand buffers and the result writeback path of the accelerator datapath.

Parameters:
- DATA_WIDTH, 8: operand width in bits.
- ACC_WIDTH, 24: accumulator and result width in bits; must be >= 2*DATA_WIDTH.
- N, 4: array dimension (N x N PEs); N >= 2.
- K_WIDTH, 16: width of the k_len input.
- SIGNED, 0: 0 = unsigned multiply, 1 = two's-complement multiply with sign-extension into the accumulator.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: single-cycle pulse that starts a job; sampled only in IDLE.
- k_len, input, K_WIDTH: inner dimension K; sampled on the cycle start is accepted.
- a_col, input, N*DATA_WIDTH: A[i][k] for i = 0..N-1; row i is in bits [i*DW +: DW].
- b_row, input, N*DATA_WIDTH: B[k][j] for j = 0..N-1; column j is in bits [j*DW +: DW].
- in_valid, input, 1: a_col/b_row beat is valid.
- in_ready, output, 1: engine accepts a beat this cycle.
- out_data, output, ACC_WIDTH: result C[r][c].
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts the result.
- out_last, output, 1: marks the final result, C[N-1][N-1].
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse on completion of a job.

Behaviour:
- Reset: state = IDLE, all accumulators = 0, all pipeline data/valid registers = 0. in_ready, out_valid, out_last, busy and done are 0; out_data = 0. Reset asserted mid-job aborts the job with no done pulse.
- FSM states: IDLE, FEED, DRAIN, OUT.
- IDLE:
  - start=1 clears all accumulators and latches k_len.
  - If k_len != 0, go to FEED; if k_len == 0, go to DRAIN.
  - start in any other state is ignored.
- FEED:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready. Beat count reaches k_len -> go to DRAIN the cycle after the last accept.
  - in_valid low injects a bubble (valid=0) into the array.
- Skew:
  - Row i west input is delayed by i registers; column j north input is delayed by j registers.
  - Each data element carries a valid bit through every register.
- PE(i,j):
  - Registers its east and south outputs, including valid, each cycle.
  - When incoming west valid && north valid: acc <= acc + a*b. Otherwise acc holds.
  - The product is 2*DW bits, zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
- DRAIN: in_ready = 0. Counts exactly 2N-1 cycles, then goes to OUT. All MACs are complete at that point.
- OUT:
  - Streams N*N results in row-major order, index r*N+c.
  - out_valid = 1. out_data and out_last are held stable while out_ready = 0.
  - Advance to the next index on out_valid && out_ready.
  - out_last = 1 only at index N*N-1.
  - On acceptance of the last result: go to IDLE, and done = 1 for that following cycle.
  - The first out_valid occurs the cycle after DRAIN completes.
- Results remain in the accumulators until the next accepted start; they are not rescanned.

Test Plan:
- N=4, K=4, A = identity, B[k][j] = 4k+j+1, in_valid always 1, out_ready always 1 -> 16 results 1..16 in order; out_last on the 16th; done pulses once; first out_valid 2N-1+1 = 8 cycles after the last accepted beat.
- Same job with in_valid toggled 1,0,1,0 and out_ready low for 3 cycles at index 5 -> identical results; out_data held at C[1][1] = 6 during the stall; no duplicated or skipped results.
- k_len=0 -> no beats accepted, in_ready never high, 16 zero results, done pulses.
- SIGNED=1, DATA_WIDTH=8, all A = -128, all B = 127, K=3 -> every C = -48768 (ACC_WIDTH=24 two's complement 0xFF4180).
- SIGNED=0, ACC_WIDTH=16, all A = B = 255, K=2 -> every C = 130050 mod 65536 = 64514.
- rst pulsed in DRAIN of job 1, then start a new job with K=1, a_col = b_row = all 2 -> all 16 results = 4, with no residue from job 1; start pulses issued during FEED are ignored.

Source files
------------

// File: rtl/sys_array_mm_if.sv
// rtl/sys_array_mm_if.sv - job control, operand beat and result read-out bus of the systolic engine
interface sys_array_mm_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int N          = 4,
    parameter int K_WIDTH    = 16
);
    logic                    start;
    logic [K_WIDTH-1:0]      k_len;
    logic [N*DATA_WIDTH-1:0] a_col;
    logic [N*DATA_WIDTH-1:0] b_row;
    logic                    in_valid;
    logic                    in_ready;
    logic [ACC_WIDTH-1:0]    out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    modport master (
        output start, k_len, a_col, b_row, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, k_len, a_col, b_row, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/sys_array_mm.sv
// rtl/sys_array_mm.sv - N x N output-stationary systolic matrix-multiply engine (C = A x B)
module sys_array_mm #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int N          = 4,
    parameter int K_WIDTH    = 16,
    parameter bit SIGNED     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    sys_array_mm_if.slave mm_if
);
    localparam int DW = DATA_WIDTH;
    localparam int IW = $clog2(N * N);
    localparam int SW = IW + 1;
    localparam logic [SW-1:0]      DRAIN_LAST = SW'(2 * N - 2);
    localparam logic [SW-1:0]      OUT_LAST   = SW'(N * N - 1);
    localparam logic [SW-1:0]      SC_ONE     = SW'(1);
    localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

    state_t             state_q, state_d;
    logic [K_WIDTH-1:0] k_q, k_d, cnt_q, cnt_d;
    logic [SW-1:0]      sc_q, sc_d;
    logic               done_q, done_d;
    logic               beat, clear;

    logic [DW-1:0]        west_data [N];
    logic [N-1:0]         west_vld;
    logic [DW-1:0]        north_data [N];
    logic [N-1:0]         north_vld;
    logic [DW-1:0]        ea_q [N][N-1];
    logic                 ev_q [N][N-1];
    logic [DW-1:0]        sb_q [N-1][N];
    logic                 sv_q [N-1][N];
    logic [ACC_WIDTH-1:0] acc_q [N][N];
    logic [ACC_WIDTH-1:0] acc_flat [N*N];

    // sc_q counts drain cycles, then doubles as the row-major read-out index
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        done_d  = 1'b0;
        beat    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: if (mm_if.start) begin
                clear   = 1'b1;
                k_d     = mm_if.k_len;
                cnt_d   = '0;
                sc_d    = '0;
                state_d = (mm_if.k_len != '0) ? FEED : DRAIN;
            end
            FEED: if (mm_if.in_valid) begin
                beat  = 1'b1;
                cnt_d = cnt_q + K_ONE;
                if ((cnt_q + K_ONE) == k_q) begin
                    state_d = DRAIN;
                    sc_d    = '0;
                end
            end
            DRAIN: begin
                if (sc_q == DRAIN_LAST) begin
                    state_d = OUT;
                    sc_d    = '0;
                end else begin
                    sc_d = sc_q + SC_ONE;
                end
            end
            OUT: if (mm_if.out_ready) begin
                if (sc_q == OUT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sc_d = sc_q + SC_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            sc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            done_q  <= done_d;
        end
    end

    assign mm_if.in_ready  = (state_q == FEED);
    assign mm_if.out_valid = (state_q == OUT);
    assign mm_if.out_last  = (state_q == OUT) && (sc_q == OUT_LAST);
    assign mm_if.out_data  = (state_q == OUT) ? acc_flat[sc_q[IW-1:0]] : '0;
    assign mm_if.busy      = (state_q != IDLE);
    assign mm_if.done      = done_q;

    // Row/column i enters the array i cycles late so A[i][k] and B[k][j] meet in PE(i,j)
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_none
            assign west_data[0]  = mm_if.a_col[DW-1:0];
            assign west_vld[0]   = beat;
            assign north_data[0] = mm_if.b_row[DW-1:0];
            assign north_vld[0]  = beat;
        end else begin : g_dly
            logic [DW-1:0] a_q [i];
            logic [DW-1:0] b_q [i];
            logic [i-1:0]  av_q, bv_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_q[s] <= '0;
                        b_q[s] <= '0;
                    end
                    av_q <= '0;
                    bv_q <= '0;
                end else begin
                    a_q[0]  <= mm_if.a_col[i*DW +: DW];
                    b_q[0]  <= mm_if.b_row[i*DW +: DW];
                    av_q[0] <= beat;
                    bv_q[0] <= beat;
                    for (int s = 1; s < i; s++) begin
                        a_q[s]  <= a_q[s-1];
                        b_q[s]  <= b_q[s-1];
                        av_q[s] <= av_q[s-1];
                        bv_q[s] <= bv_q[s-1];
                    end
                end
            end
            assign west_data[i]  = a_q[i-1];
            assign west_vld[i]   = av_q[i-1];
            assign north_data[i] = b_q[i-1];
            assign north_vld[i]  = bv_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0]        a_in, b_in;
            logic                 av_in, bv_in;
            logic [ACC_WIDTH-1:0] a_x, b_x, prod;

            if (j == 0) begin : g_w_edge
                assign a_in  = west_data[i];
                assign av_in = west_vld[i];
            end else begin : g_w_pe
                assign a_in  = ea_q[i][j-1];
                assign av_in = ev_q[i][j-1];
            end
            if (i == 0) begin : g_n_edge
                assign b_in  = north_data[j];
                assign bv_in = north_vld[j];
            end else begin : g_n_pe
                assign b_in  = sb_q[i-1][j];
                assign bv_in = sv_q[i-1][j];
            end

            // Operands widened to ACC_WIDTH give the exact product modulo 2^ACC_WIDTH
            if (SIGNED) begin : g_sext
                assign a_x = {{(ACC_WIDTH-DW){a_in[DW-1]}}, a_in};
                assign b_x = {{(ACC_WIDTH-DW){b_in[DW-1]}}, b_in};
            end else begin : g_zext
                assign a_x = {{(ACC_WIDTH-DW){1'b0}}, a_in};
                assign b_x = {{(ACC_WIDTH-DW){1'b0}}, b_in};
            end
            assign prod = a_x * b_x;

            if (j < N - 1) begin : g_east
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ea_q[i][j] <= '0;
                        ev_q[i][j] <= 1'b0;
                    end else begin
                        ea_q[i][j] <= a_in;
                        ev_q[i][j] <= av_in;
                    end
                end
            end
            if (i < N - 1) begin : g_south
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sb_q[i][j] <= '0;
                        sv_q[i][j] <= 1'b0;
                    end else begin
                        sb_q[i][j] <= b_in;
                        sv_q[i][j] <= bv_in;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q[i][j] <= '0;
                end else if (clear) begin
                    acc_q[i][j] <= '0;
                end else if (av_in && bv_in) begin
                    acc_q[i][j] <= acc_q[i][j] + prod;
                end
            end

            assign acc_flat[i*N+j] = acc_q[i][j];
        end
    end
endmodule
